c1_bus_arbiter: RTL and testbench
=================================

// Module: c1_bus_arbiter
// PURPOSE
//  Synthesizable C1-bus master shared by N_REQ requesters (CPU core, DMA, debug port) in front of the cache.
//  - Arbitrates between requesters and latches the winning request.
//  - Sequences the two-phase C1 address/command protocol, releases the bus and waits for C1_RESPONSE (3'd7).
//  - Returns read data, or write/invalidate completion, to the winning requester.
//  - The C1 inout nets are split into _o/_oe/_i triples; tri-state buffers sit at the top level.
// PARAMETERS
//  MEM_ADDR_SIZE     19  byte-address width
//  BUS_SIZE          16  C1 data bus width
//  CACHE_OFFSET_SIZE  4  line-offset bits sent in address phase 2
//  N_REQ              2  number of requesters (>=2)
// PORTS
//  clk          in   1                 clock, all state on posedge
//  rst_n        in   1                 asynchronous, active-low reset
//  req_valid    in   N_REQ             per-requester request
//  req_cmd      in   N_REQ*3           C1 command code per requester
//  req_addr     in   N_REQ*MEM_ADDR_SIZE  byte address per requester
//  req_wdata    in   N_REQ*2*BUS_SIZE  write data per requester
//  req_ready    out  N_REQ             one-hot, 1-cycle pulse: request accepted
//  rsp_valid    out  N_REQ             one-hot, 1-cycle pulse: transaction complete
//  rsp_rdata    out  2*BUS_SIZE        read data; valid while rsp_valid
//  c1_addr_o    out  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  address bus drive value
//  c1_addr_oe   out  1                 address bus drive enable
//  c1_data_o    out  BUS_SIZE          data bus drive value
//  c1_data_oe   out  1                 data bus drive enable
//  c1_data_i    in   BUS_SIZE          data bus sampled value
//  c1_cmd_o     out  3                 command bus drive value
//  c1_cmd_oe    out  1                 command bus drive enable
//  c1_cmd_i     in   3                 command bus sampled value
// BEHAVIOUR
//  Reset (async, on rst_n low, including mid-transaction):
//  - State returns to IDLE; all *_oe=0; req_ready=0; rsp_valid=0; rsp_rdata=0; all _o=0; arbitration pointer=0.
//  Handshake:
//  - In IDLE, if any req_valid, grant one requester: pulse its req_ready and latch its cmd/addr/wdata.
//  - The requester holds req_valid until req_ready; it may drop or change the request after req_ready.
//  FSM: IDLE -> PH1 -> PH2 -> WAIT -> [RD2] -> IDLE
//  - PH1:  cmd_oe=1, c1_cmd_o=cmd; addr_oe=1, c1_addr_o=addr[MSB:OFFSET]; for writes data_oe=1, c1_data_o=wdata[15:0].
//  - PH2:  cmd is still driven; c1_addr_o={0,addr[OFFSET-1:0]}; for WRITE32 c1_data_o=wdata[31:16], otherwise data low half held.
//  - WAIT: all oe=0 (bus released). Leave WAIT on the first cycle with c1_cmd_i===3'd7.
//      - READ8: rdata={24'b0,c1_data_i[7:0]}.
//      - READ16: rdata zero-extended from c1_data_i.
//      - READ32: capture the low half and go to RD2.
//      - Writes and INV_LINE: rdata=0.
//      - Non-READ32 commands return to IDLE with rsp_valid.
//  - RD2:  capture c1_data_i as rdata[31:16]; rsp_valid; go to IDLE.
//  Latency:
//  - Request accept to first bus drive: 1 cycle.
//  - Response sample to rsp_valid: 1 cycle (registered).
//  - Back-to-back: a new grant is possible in the cycle after rsp_valid.
//  Boundary cases:
//  - req_cmd NOP(0) or RESP(7): accepted, no bus activity, rsp_valid next cycle with rdata=0.
//  - c1_cmd_i X/Z in WAIT: remain in WAIT; no timeout.
//  - Simultaneous requests: see CONFIGURATION. Requests are never granted while the FSM is outside IDLE.
// CONFIGURATION
//  C1_ARB_ROUND_ROBIN_EN defined:
//  - Round-robin arbitration. Pointer advances to (granted+1)%N_REQ on each grant; search starts at the pointer.
//  C1_ARB_ROUND_ROBIN_EN undefined:
//  - Fixed priority, lowest index wins. Pointer logic is absent.
// STRUCTURE
//  - c1_bus_pkg: C1 command localparams (C1_NOP..C1_RESPONSE=3'd7), FSM state enum, is_read/is_write/is_32 helper functions.
//  - Sub-module c1_arb_grant: combinational one-hot grant from req_valid and pointer; the pointer register is macro-gated.
//  - Top level holds the FSM, request latches and output registers.
// TESTING
//  1. rst_n low mid-PH2 of WRITE16 -> all oe=0 in the same cycle; state IDLE; rsp_valid never pulses.
//  2. Req0 READ8 at 19'h00020; cache answers cmd=7, data=16'hA5C3 after 3 WAIT cycles
//     -> PH1 addr=15'h0002, PH2 addr=4'h0, rsp_valid[0], rdata=32'h000000C3.
//  3. Req1 WRITE32 at 19'h00150, wdata=32'h12345678
//     -> PH1 data=16'h5678, PH2 data=16'h1234, cmd=3'd7 pulse, then rsp_valid[1].
//  4. READ32: response halves 16'hBEEF then 16'hDEAD -> rdata=32'hDEADBEEF, exactly one rsp_valid.
//  5. Both requesters valid continuously, 4 transactions:
//     - with RR_EN: grants 0,1,0,1.
//     - without RR_EN: grants 0,0,0,0.
//  6. req_cmd=3'd0 -> c1_cmd_oe stays 0, rsp_valid 2 cycles after req_valid, rdata=0.

Source files
------------

// File: rtl/c1_bus_pkg.sv
// Shared C1 bus definitions: command codes, arbiter FSM state encoding and command classifiers.
// 3-bit code space: 7 is reserved for the cache's response, so there is no 8-bit write command.
package c1_bus_pkg;

    localparam logic [2:0] C1_NOP      = 3'd0;
    localparam logic [2:0] C1_READ8    = 3'd1;
    localparam logic [2:0] C1_READ16   = 3'd2;
    localparam logic [2:0] C1_READ32   = 3'd3;
    localparam logic [2:0] C1_INV_LINE = 3'd4;
    localparam logic [2:0] C1_WRITE16  = 3'd5;
    localparam logic [2:0] C1_WRITE32  = 3'd6;
    localparam logic [2:0] C1_RESPONSE = 3'd7;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PH1  = 3'd1;
    localparam logic [2:0] ST_PH2  = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_RD2  = 3'd4;
    localparam logic [2:0] ST_NOP  = 3'd5;

    function automatic logic is_read(input logic [2:0] cmd);
        return cmd inside {C1_READ8, C1_READ16, C1_READ32};
    endfunction

    function automatic logic is_write(input logic [2:0] cmd);
        return cmd inside {C1_WRITE16, C1_WRITE32};
    endfunction

    function automatic logic is_32(input logic [2:0] cmd);
        return cmd inside {C1_READ32, C1_WRITE32};
    endfunction

    // NOP and RESPONSE are completed locally without touching the bus.
    function automatic logic is_bus_cmd(input logic [2:0] cmd);
        return (cmd != C1_NOP) && (cmd != C1_RESPONSE);
    endfunction

endpackage

// File: rtl/c1_bus_arbiter_if.sv
// Requester handshake plus the split C1 bus (_o/_oe/_i); master is the arbiter, slave is the environment.
interface c1_bus_arbiter_if #(
    parameter int N_REQ             = 2,
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4
);
    logic [N_REQ-1:0]                           req_valid;
    logic [N_REQ-1:0][2:0]                      req_cmd;
    logic [N_REQ-1:0][MEM_ADDR_SIZE-1:0]        req_addr;
    logic [N_REQ-1:0][2*BUS_SIZE-1:0]           req_wdata;
    logic [N_REQ-1:0]                           req_ready;
    logic [N_REQ-1:0]                           rsp_valid;
    logic [2*BUS_SIZE-1:0]                      rsp_rdata;
    logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] c1_addr_o;
    logic                                       c1_addr_oe;
    logic [BUS_SIZE-1:0]                        c1_data_o;
    logic                                       c1_data_oe;
    logic [BUS_SIZE-1:0]                        c1_data_i;
    logic [2:0]                                 c1_cmd_o;
    logic                                       c1_cmd_oe;
    logic [2:0]                                 c1_cmd_i;

    modport master (
        input  req_valid, req_cmd, req_addr, req_wdata, c1_data_i, c1_cmd_i,
        output req_ready, rsp_valid, rsp_rdata,
               c1_addr_o, c1_addr_oe, c1_data_o, c1_data_oe, c1_cmd_o, c1_cmd_oe
    );

    modport slave (
        output req_valid, req_cmd, req_addr, req_wdata, c1_data_i, c1_cmd_i,
        input  req_ready, rsp_valid, rsp_rdata,
               c1_addr_o, c1_addr_oe, c1_data_o, c1_data_oe, c1_cmd_o, c1_cmd_oe
    );
endinterface

// File: rtl/c1_arb_grant.sv
// One-hot grant from req_valid. C1_ARB_ROUND_ROBIN_EN selects round-robin with a rotating
// pointer; otherwise fixed priority (lowest index wins) and no pointer state exists.
module c1_arb_grant #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic             grant_en_i,
    output logic [N_REQ-1:0] grant_o
);
`ifdef C1_ARB_ROUND_ROBIN_EN
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;

    // Walk offsets farthest-first so the valid requester nearest the pointer overwrites the rest.
    always_comb begin
        grant_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (req_valid_i[j] && (j == (int'(ptr_q) + k) % N_REQ)) begin
                    grant_o    = '0;
                    grant_o[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int j = 0; j < N_REQ; j++)
            if (grant_en_i && grant_o[j]) ptr_d = PW'((j + 1) % N_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    logic unused_fixed;
    assign unused_fixed = ^{clk, rst_n, grant_en_i};

    always_comb begin
        grant_o = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_valid_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
            end
        end
    end
`endif
endmodule

// File: rtl/c1_bus_arbiter.sv
// C1 bus master shared by N_REQ requesters: grant, two-phase address/command, wait for response,
// return data. Arbitration policy follows C1_ARB_ROUND_ROBIN_EN (see c1_arb_grant).
module c1_bus_arbiter
    import c1_bus_pkg::*;
#(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int BUS_SIZE          = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int N_REQ             = 2
) (
    input logic              clk,
    input logic              rst_n,
    c1_bus_arbiter_if.master bus
);
    localparam int AW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
    localparam int OW = CACHE_OFFSET_SIZE;
    localparam int DW = 2 * BUS_SIZE;

    typedef struct packed {
        logic [2:0]               cmd;
        logic [MEM_ADDR_SIZE-1:0] addr;
        logic [DW-1:0]            wdata;
    } req_t;

    // Only what is still needed after phase 1 is kept; the rest goes straight to the bus registers.
    typedef struct packed {
        logic [2:0]          cmd;
        logic [OW-1:0]       off;
        logic [BUS_SIZE-1:0] whi;
    } lat_t;

    logic [2:0]          state_q, state_d;
    lat_t                lat_q, lat_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    req_ready_q, req_ready_d;
    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic [AW-1:0]       addr_o_q, addr_o_d;
    logic                addr_oe_q, addr_oe_d;
    logic [BUS_SIZE-1:0] data_o_q, data_o_d;
    logic                data_oe_q, data_oe_d;
    logic [2:0]          cmd_o_q, cmd_o_d;
    logic                cmd_oe_q, cmd_oe_d;

    logic [N_REQ-1:0]    gnt;
    logic                grant_en;
    req_t                sel;

    c1_arb_grant #(.N_REQ(N_REQ)) u_grant (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid_i(bus.req_valid),
        .grant_en_i (grant_en),
        .grant_o    (gnt)
    );

    assign grant_en = (state_q == ST_IDLE) && (|gnt);

    always_comb begin
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel.cmd   = bus.req_cmd[i];
                sel.addr  = bus.req_addr[i];
                sel.wdata = bus.req_wdata[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        gnt_d       = gnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        addr_o_d    = addr_o_q;
        addr_oe_d   = addr_oe_q;
        data_o_d    = data_o_q;
        data_oe_d   = data_oe_q;
        cmd_o_d     = cmd_o_q;
        cmd_oe_d    = cmd_oe_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    req_ready_d = gnt;
                    gnt_d       = gnt;
                    lat_d.cmd   = sel.cmd;
                    lat_d.off   = sel.addr[OW-1:0];
                    lat_d.whi   = sel.wdata[DW-1:BUS_SIZE];
                    if (is_bus_cmd(sel.cmd)) begin
                        // Phase-1 values are registered here so they appear the cycle after accept.
                        state_d   = ST_PH1;
                        cmd_oe_d  = 1'b1;
                        cmd_o_d   = sel.cmd;
                        addr_oe_d = 1'b1;
                        addr_o_d  = sel.addr[MEM_ADDR_SIZE-1:OW];
                        data_oe_d = is_write(sel.cmd);
                        if (is_write(sel.cmd)) data_o_d = sel.wdata[BUS_SIZE-1:0];
                    end else begin
                        state_d = ST_NOP;
                    end
                end
            end
            ST_PH1: begin
                state_d  = ST_PH2;
                addr_o_d = AW'(lat_q.off);
                if (is_write(lat_q.cmd) && is_32(lat_q.cmd)) data_o_d = lat_q.whi;
            end
            ST_PH2: begin
                state_d   = ST_WAIT;
                cmd_oe_d  = 1'b0;
                addr_oe_d = 1'b0;
                data_oe_d = 1'b0;
            end
            ST_WAIT: begin
                // An undriven or unknown command bus never compares equal, so WAIT simply persists.
                if (bus.c1_cmd_i == C1_RESPONSE) begin
                    if (is_read(lat_q.cmd) && is_32(lat_q.cmd)) begin
                        rdata_d = DW'(bus.c1_data_i);
                        state_d = ST_RD2;
                    end else begin
                        rdata_d = '0;
                        if (lat_q.cmd == C1_READ8)  rdata_d = DW'(bus.c1_data_i[7:0]);
                        if (lat_q.cmd == C1_READ16) rdata_d = DW'(bus.c1_data_i);
                        rsp_valid_d = gnt_q;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_RD2: begin
                rdata_d     = {bus.c1_data_i, rdata_q[BUS_SIZE-1:0]};
                rsp_valid_d = gnt_q;
                state_d     = ST_IDLE;
            end
            ST_NOP: begin
                rdata_d     = '0;
                rsp_valid_d = gnt_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            gnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            addr_o_q    <= '0;
            addr_oe_q   <= 1'b0;
            data_o_q    <= '0;
            data_oe_q   <= 1'b0;
            cmd_o_q     <= '0;
            cmd_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            gnt_q       <= gnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            addr_o_q    <= addr_o_d;
            addr_oe_q   <= addr_oe_d;
            data_o_q    <= data_o_d;
            data_oe_q   <= data_oe_d;
            cmd_o_q     <= cmd_o_d;
            cmd_oe_q    <= cmd_oe_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata  = rdata_q;
    assign bus.c1_addr_o  = addr_o_q;
    assign bus.c1_addr_oe = addr_oe_q;
    assign bus.c1_data_o  = data_o_q;
    assign bus.c1_data_oe = data_oe_q;
    assign bus.c1_cmd_o   = cmd_o_q;
    assign bus.c1_cmd_oe  = cmd_oe_q;

endmodule

// File: tb/tb_c1_bus_arbiter.sv
// Transaction-level bench for c1_bus_arbiter: directed scenarios plus randomized requests,
// each checked cycle by cycle against a protocol model held here.
module tb_c1_bus_arbiter;
    import c1_bus_pkg::*;

    localparam int N  = 2;
    localparam int MA = 19;
    localparam int BS = 16;
    localparam int CO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    c1_bus_arbiter_if #(.N_REQ(N), .MEM_ADDR_SIZE(MA), .BUS_SIZE(BS), .CACHE_OFFSET_SIZE(CO)) bus ();

    c1_bus_arbiter #(.MEM_ADDR_SIZE(MA), .BUS_SIZE(BS), .CACHE_OFFSET_SIZE(CO), .N_REQ(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ptr    = 0;  // model round-robin pointer

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int arb(input logic [N-1:0] v);
`ifdef C1_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
        return 0;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [2:0] c, input logic [15:0] lo, input logic [15:0] hi);
        case (c)
            C1_READ8:  return {24'h0, lo[7:0]};
            C1_READ16: return {16'h0, lo};
            C1_READ32: return {hi, lo};
            default:   return 32'h0;
        endcase
    endfunction

    task automatic put(input int i, input logic [2:0] c, input logic [18:0] a, input logic [31:0] d);
        bus.req_valid[i] = 1'b1;
        bus.req_cmd[i]   = c;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
    endtask

    // Called with the DUT idle and requests already presented for the coming edge.
    task automatic serve(input bit hold, input int nwait, input logic [15:0] lo, input logic [15:0] hi,
                         output int got, output logic [31:0] rd);
        int w;
        logic [2:0] c;
        logic [18:0] a;
        logic [31:0] d;
        bit busc, wr;
        w = arb(bus.req_valid);
        c = bus.req_cmd[w];
        a = bus.req_addr[w];
        d = bus.req_wdata[w];
        ptr  = (w + 1) % N;
        busc = (c != C1_NOP) && (c != C1_RESPONSE);
        wr   = (c == C1_WRITE16) || (c == C1_WRITE32);
        tick();
        got = -1;
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) got = i;
        chk("ready", 32'(bus.req_ready), 32'(1 << w));
        chk("rsp_idle", 32'(bus.rsp_valid), 32'h0);
        if (!hold) bus.req_valid = '0;
        if (!busc) begin
            chk("nop_oe", 32'({bus.c1_cmd_oe, bus.c1_addr_oe, bus.c1_data_oe}), 32'h0);
            tick();
        end else begin
            chk("ph1_cmd", 32'({bus.c1_cmd_oe, bus.c1_cmd_o}), 32'({1'b1, c}));
            chk("ph1_addr", 32'({bus.c1_addr_oe, bus.c1_addr_o}), 32'({1'b1, a[18:4]}));
            chk("ph1_data", 32'({bus.c1_data_oe, wr ? bus.c1_data_o : 16'h0}),
                32'({wr, wr ? d[15:0] : 16'h0}));
            tick();
            chk("ph2_cmd", 32'({bus.c1_cmd_oe, bus.c1_cmd_o}), 32'({1'b1, c}));
            chk("ph2_addr", 32'({bus.c1_addr_oe, bus.c1_addr_o}), 32'({1'b1, 11'h0, a[3:0]}));
            chk("ph2_data", 32'({bus.c1_data_oe, wr ? bus.c1_data_o : 16'h0}),
                32'({wr, wr ? ((c == C1_WRITE32) ? d[31:16] : d[15:0]) : 16'h0}));
            chk("ready_pulse", 32'(bus.req_ready), 32'h0);
            for (int i = 0; i <= nwait; i++) begin
                tick();
                chk("wait_oe", 32'({bus.c1_cmd_oe, bus.c1_addr_oe, bus.c1_data_oe, bus.rsp_valid}), 32'h0);
                if (i == nwait) begin
                    bus.c1_cmd_i  = C1_RESPONSE;
                    bus.c1_data_i = lo;
                end else begin
                    bus.c1_cmd_i  = 3'($urandom_range(0, 6));
                    bus.c1_data_i = 16'($urandom);
                end
            end
            tick();
            bus.c1_cmd_i = C1_NOP;
            if (c == C1_READ32) begin
                chk("rd2_rsp", 32'(bus.rsp_valid), 32'h0);
                bus.c1_data_i = hi;
                tick();
            end
            bus.c1_data_i = 16'($urandom);
        end
        chk("rsp", 32'(bus.rsp_valid), 32'(1 << w));
        chk("rdata", bus.rsp_rdata, exp_rdata(c, lo, hi));
        rd = bus.rsp_rdata;
    endtask

    initial begin
        int g;
        logic [31:0] rd;
        int exp5 [4];
`ifdef C1_ARB_ROUND_ROBIN_EN
        exp5 = '{0, 1, 0, 1};
`else
        exp5 = '{0, 0, 0, 0};
`endif
        bus.req_valid = '0;
        bus.req_cmd   = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.c1_data_i = '0;
        bus.c1_cmd_i  = C1_NOP;
        #3;
        chk("rst_oe", 32'({bus.c1_cmd_oe, bus.c1_addr_oe, bus.c1_data_oe}), 32'h0);
        chk("rst_o", 32'({bus.c1_cmd_o, bus.c1_data_o}), 32'h0);
        chk("rst_addr", 32'(bus.c1_addr_o), 32'h0);
        chk("rst_hs", 32'({bus.req_ready, bus.rsp_valid}), 32'h0);
        chk("rst_rdata", bus.rsp_rdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while WRITE16 is in phase 2
        put(0, C1_WRITE16, 19'h00340, 32'hCAFE_F00D);
        tick();
        bus.req_valid = '0;
        tick();
        chk("t1_ph2_oe", 32'({bus.c1_cmd_oe, bus.c1_addr_oe, bus.c1_data_oe}), 32'h7);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_oe", 32'({bus.c1_cmd_oe, bus.c1_addr_oe, bus.c1_data_oe}), 32'h0);
        chk("t1_rst_o", 32'({bus.c1_cmd_o, bus.c1_data_o, bus.c1_addr_o}), 32'h0);
        ptr = 0;
        tick();
        rst_n = 1'b1;
        repeat (4) begin
            tick();
            chk("t1_no_rsp", 32'({bus.rsp_valid, bus.req_ready}), 32'h0);
        end

        // READ8, three WAIT cycles before the response
        put(0, C1_READ8, 19'h00020, 32'h0);
        serve(1'b0, 2, 16'hA5C3, 16'h0, g, rd);
        chk("t2_gnt", 32'(g), 32'd0);
        chk("t2_rdata", rd, 32'h0000_00C3);

        // READ32 assembled from two response cycles
        put(0, C1_READ32, 19'h7ABC4, 32'h0);
        serve(1'b0, 0, 16'hBEEF, 16'hDEAD, g, rd);
        chk("t4_rdata", rd, 32'hDEAD_BEEF);
        tick();
        chk("t4_one_pulse", 32'(bus.rsp_valid), 32'h0);

        // WRITE32 from requester 1
        put(1, C1_WRITE32, 19'h00150, 32'h1234_5678);
        serve(1'b0, 1, 16'h1111, 16'h2222, g, rd);
        chk("t3_gnt", 32'(g), 32'd1);
        chk("t3_rdata", rd, 32'h0);

        // Both requesters held valid across four transactions
        put(0, C1_READ16, 19'h01230, 32'h0);
        put(1, C1_INV_LINE, 19'h04560, 32'h0);
        for (int k = 0; k < 4; k++) begin
            serve(1'b1, 1, 16'($urandom), 16'($urandom), g, rd);
            chk("t5_gnt", 32'(g), 32'(exp5[k]));
        end
        bus.req_valid = '0;
        tick();

        // NOP and RESPONSE codes complete without bus activity
        put(0, C1_NOP, 19'h1FFFF, 32'hFFFF_FFFF);
        serve(1'b0, 0, 16'h0, 16'h0, g, rd);
        chk("t6_rdata", rd, 32'h0);
        put(1, C1_RESPONSE, 19'h00010, 32'h0);
        serve(1'b0, 0, 16'h0, 16'h0, g, rd);
        chk("t6_gnt", 32'(g), 32'd1);

        repeat (40) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                bus.req_valid[i] = m[i];
                bus.req_cmd[i]   = 3'($urandom);
                bus.req_addr[i]  = 19'($urandom);
                bus.req_wdata[i] = $urandom;
            end
            serve(1'($urandom_range(0, 1)), $urandom_range(0, 3), 16'($urandom), 16'($urandom), g, rd);
        end
        bus.req_valid = '0;
        tick();
        chk("end_idle", 32'({bus.req_ready, bus.rsp_valid, bus.c1_cmd_oe}), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
